// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and constants for the bit-serial add/subtract
//               sequencer: sequencer state encoding, op encodings and a
//               helper that sizes the bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit counter width: max(1, clog2(WIDTH)) so WIDTH=1 still gets a flop.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_cell.sv
`default_nettype none
// ============================================================================
// Module      : addsub_cell
// Description : Combinational 1-bit full adder / full subtractor.
//               op=OP_ADD : s = a^b^cin, cout = carry out
//               op=OP_SUB : s = a^b^cin, cout = borrow out (cin is borrow in)
// Ports       : a, b  - operand bits
//               cin   - carry in (add) or borrow in (sub)
//               op    - operation select
//               s     - sum / difference bit
//               cout  - carry out (add) or borrow out (sub)
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_cell
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cout
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign s      = w_prop ^ cin;

    // Sum and difference share the same XOR; only the carry/borrow differs.
    assign cout = (op == OP_SUB) ? ((~a & b) | (cin & ~w_prop))
                                 : ((a & b)  | (cin &  w_prop));

endmodule
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_ctrl
// Description : Bit-serial add/subtract sequencer. One shared 1-bit
//               add/sub cell processes the operands LSB first, one bit per
//               clock, with the carry/borrow held in a flop between bits.
//               One operation takes WIDTH+2 cycles start-to-start.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               start  - request, accepted only while ready=1
//               ready  - high in IDLE (combinational from state)
//               op     - 0 add, 1 subtract; sampled with start
//               a, b   - operands; sampled with start
//               result - sum/difference mod 2^WIDTH (registered)
//               cout   - final carry (add) or borrow (sub) (registered)
//               done   - one-cycle completion pulse (registered)
//               busy   - high in RUN (and DONE), equals ~ready
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             done,
    output logic             busy
);

    localparam int             c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_op;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_done;

    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_result_next;

    addsub_cell u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .op   (r_op),
        .s    (w_s),
        .cout (w_cout)
    );

    // New bit enters at the MSB; after WIDTH shifts the LSB-first stream
    // lands in natural bit order. Written this way so WIDTH=1 needs no slice.
    always_comb begin
        w_result_next             = r_result >> 1;
        w_result_next[WIDTH-1]    = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_op     <= OP_ADD;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_op    <= op;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result <= w_result_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_cout  <= w_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready  = (r_state == IDLE);
    assign busy   = ~ready;
    assign result = r_result;
    assign cout   = r_cout;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer.
- Shares one 1-bit full-adder/full-subtractor cell across all WIDTH bit positions, processing LSB first, one bit per clock.
- Holds the carry/borrow in a flop between bits.
- Sits between a requester using a start/ready handshake and the combinational 1-bit arithmetic cell. It trades latency for area against a ripple-carry array.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when ready=1
ready  output  1  high iff state is IDLE; combinational from state
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
result  output  WIDTH  sum or difference mod 2^WIDTH; registered
cout  output  1  final carry (add) or final borrow (sub); registered
done  output  1  one-cycle completion pulse; registered
busy  output  1  high in RUN; equals ~ready

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, ready=1, busy=0, done=0
  - result=0, cout=0
  - internal carry/borrow flop=0, bit counter=0
  - operand shift registers=0
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge latches a, b and op into shift registers and clears the carry/borrow flop and counter.
  - Next state is RUN.
  - result and cout keep their previous values until the first RUN edge.
- RUN, each edge:
  - The cell takes a_sh[0], b_sh[0] and the carry/borrow flop, using op_q.
  - The output bit shifts into result at the MSB; result shifts right by 1.
  - a_sh and b_sh shift right by 1.
  - The carry/borrow flop updates. The counter increments.
- End of RUN:
  - On the edge where counter==WIDTH-1, the state goes to DONE.
  - done is driven to 1, and cout takes the cell's carry/borrow output from that edge.
- DONE:
  - Lasts exactly one cycle; next state is IDLE.
  - done returns to 0 on the next edge.
- Latency:
  - start sampled at edge k gives done=1 during the cycle after edge k+WIDTH.
  - ready=1 again after edge k+WIDTH+1.
  - Throughput is one operation per WIDTH+2 cycles.
- Arithmetic:
  - Add: result = (a+b) mod 2^WIDTH, cout = bit WIDTH of a+b.
  - Sub: result = (a-b) mod 2^WIDTH, cout = 1 iff a<b (unsigned).
- Cell equations:
  - Add: s = a^b^c, c' = ab | c(a^b).
  - Sub: d = a^b^bin, bout = (~a)b | bin·~(a^b).
- start while RUN or DONE: ignored, with no effect on the operands or op in flight.
- result and cout are valid from the done cycle. They stay stable until the first RUN edge of the next operation.
- Intermediate result bits during RUN are not valid and must not be consumed.
- rst_n low mid-operation: the immediate asynchronous return to reset values applies; the in-flight operation is discarded.
- After rst_n deasserts, the first edge may accept start.
- Counter width is max(1, $clog2(WIDTH)).
- WIDTH=1: RUN lasts exactly one edge, then DONE.

Decomposition:
- Shared package addsub_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1
- Sub-module addsub_cell: combinational 1-bit full adder/full subtractor selected by op.
  - Ports: a, b, cin, op, s, cout.
  - Instantiated once in serial_addsub_ctrl.

Test Plan:
- WIDTH=8, op=0, a=8'h5A, b=8'h3C, start at edge k -> done=1 only in the cycle after edge k+8; result=8'h96, cout=0; ready=1 after edge k+9.
- op=0, a=8'hFF, b=8'h01 -> result=8'h00, cout=1. Then op=0, a=8'h00, b=8'h00 -> result=8'h00, cout=0.
- op=1, a=8'h10, b=8'h20 -> result=8'hF0, cout=1. Then op=1, a=8'h3C, b=8'h3C -> result=8'h00, cout=0.
- During RUN of 8'h5A+8'h3C, pulse start with op=1, a=8'hFF, b=8'h11 -> ignored; ready=0 throughout RUN; result=8'h96, cout=0.
- Drop rst_n low asynchronously after 3 RUN edges -> result=0, cout=0, done=0, ready=1 immediately. After release, 8'h01+8'h01 gives 8'h02, cout=0.
- Hold start=1 continuously with new operands each op -> operations accepted at exactly every WIDTH+2 edges, each result correct; cross-check with a random 200-op loop against a+b / a-b.
